// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC widths, angle constants, sector codes and result record
package cordic_pkg;

    localparam int Q_WIDTH       = 16;
    localparam int RES_WIDTH     = Q_WIDTH + 1;
    localparam int SECTOR_WIDTH  = 2;
    localparam int DEG_SUM_WIDTH = RES_WIDTH + 1;

    // Angles are Q7.8 degrees: 90 * 256 and 360 * 256
    localparam logic [RES_WIDTH-1:0] DEG_90  = 17'd23040;
    localparam logic [RES_WIDTH-1:0] DEG_360 = 17'd92160;

    typedef enum logic [SECTOR_WIDTH-1:0] {
        SEC_Q1 = 2'd0,
        SEC_Q2 = 2'd1,
        SEC_Q3 = 2'd2,
        SEC_Q4 = 2'd3
    } sector_t;

    typedef struct packed {
        logic [RES_WIDTH-1:0] x;
        logic [RES_WIDTH-1:0] y;
        logic [RES_WIDTH-1:0] degree;
        logic                 mode;
    } cordic_result_t;

    // Folded angle plus sector offset, brought back into [0,360); one subtract suffices
    function automatic logic [RES_WIDTH-1:0] unfold_degree(
        input logic [Q_WIDTH-1:0]      degree,
        input logic [SECTOR_WIDTH-1:0] sector
    );
        logic [DEG_SUM_WIDTH-1:0] sum;
        sum = {2'b00, degree} + DEG_SUM_WIDTH'(sector) * DEG_SUM_WIDTH'(DEG_90);
        if (sum >= DEG_SUM_WIDTH'(DEG_360)) begin
            sum = sum - DEG_SUM_WIDTH'(DEG_360);
        end
        return sum[RES_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// rtl/cordic_result_fifo.sv - synchronous result FIFO with wrap-bit pointers
module cordic_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/cordic_result_collector.sv
// rtl/cordic_result_collector.sv - tracks pipeline slots, unfolds quadrants, buffers results, issues credit
module cordic_result_collector
    import cordic_pkg::*;
#(
    parameter int UNSIGNED_OUTPUT_WIDTH = 16,
    parameter int SECTOR_FLAG_WIDTH     = 2,
    parameter int LATENCY               = 7,
    parameter int FIFO_DEPTH            = 4,
    parameter int TAG_WIDTH             = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    output logic                             issue_ok,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] pipe_degree,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] pipe_x,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] pipe_y,
    input  logic [SECTOR_FLAG_WIDTH-1:0]     pipe_sector,
    input  logic                             pipe_arctan_en,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [UNSIGNED_OUTPUT_WIDTH:0]   res_x,
    output logic [UNSIGNED_OUTPUT_WIDTH:0]   res_y,
    output logic [UNSIGNED_OUTPUT_WIDTH:0]   res_degree,
    output logic                             res_mode,
    output logic [TAG_WIDTH-1:0]             res_tag,
    output logic                             overflow_err
);

    localparam int RW = UNSIGNED_OUTPUT_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(LATENCY + FIFO_DEPTH + 2) + 1;
    localparam int EW = $bits(cordic_result_t) + TAG_WIDTH;

    logic [LATENCY-1:0]   dl_valid;
    logic [TAG_WIDTH-1:0] dl_tag [LATENCY];
    logic                 tail_valid;
    logic [TAG_WIDTH-1:0] tail_tag;

    logic [RW-1:0]        x_ext;
    logic [RW-1:0]        y_ext;
    cordic_result_t       unfolded;
    cordic_result_t       post_res;
    logic                 post_valid;
    logic [TAG_WIDTH-1:0] post_tag;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic [CW-1:0]        fifo_count;
    logic [EW-1:0]        fifo_rd_data;
    logic [EW-1:0]        out_entry;
    cordic_result_t       out_res;
    logic [TAG_WIDTH-1:0] out_tag;

    logic                 credit_en;
    logic [PW-1:0]        pending;

    assign tail_valid = dl_valid[LATENCY-1];
    assign tail_tag   = dl_tag[LATENCY-1];

    // Delay line mirrors the pipeline: its tail is set in the cycle pipe_* carries that sample
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_tag[i] <= '0;
            end
        end else begin
            dl_valid  <= {dl_valid[LATENCY-2:0], in_valid};
            dl_tag[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                dl_tag[i] <= dl_tag[i-1];
            end
        end
    end

    assign x_ext = RW'(pipe_x);
    assign y_ext = RW'(pipe_y);

    // Undo quadrant folding: rotation mode rotates the vector back by sector*90 degrees
    always_comb begin
        unfolded.x      = x_ext;
        unfolded.y      = y_ext;
        unfolded.degree = unfold_degree(pipe_degree, pipe_sector);
        unfolded.mode   = pipe_arctan_en;
        if (!pipe_arctan_en) begin
            case (sector_t'(pipe_sector))
                SEC_Q2: begin
                    unfolded.x = -y_ext;
                    unfolded.y = x_ext;
                end
                SEC_Q3: begin
                    unfolded.x = -x_ext;
                    unfolded.y = -y_ext;
                end
                SEC_Q4: begin
                    unfolded.x = y_ext;
                    unfolded.y = -x_ext;
                end
                default: begin
                    unfolded.x = x_ext;
                    unfolded.y = y_ext;
                end
            endcase
        end
    end

    // Post stage: register the unfolded result only when the tail marks a real sample
    always_ff @(posedge clk) begin
        if (reset) begin
            post_valid <= 1'b0;
            post_res   <= '0;
            post_tag   <= '0;
        end else begin
            post_valid <= tail_valid;
            if (tail_valid) begin
                post_res <= unfolded;
                post_tag <= tail_tag;
            end
        end
    end

    assign fifo_pop  = res_ready && !fifo_empty;
    assign fifo_drop = post_valid && fifo_full && !fifo_pop;

    cordic_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (post_valid),
        .push_data ({post_tag, post_res}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs read as zero whenever nothing is buffered
    assign out_entry  = fifo_empty ? '0 : fifo_rd_data;
    assign {out_tag, out_res} = out_entry;
    assign res_valid  = !fifo_empty;
    assign res_x      = out_res.x;
    assign res_y      = out_res.y;
    assign res_degree = out_res.degree;
    assign res_mode   = out_res.mode;
    assign res_tag    = out_tag;

    // Every launched, not-yet-popped sample holds a credit until it leaves the FIFO
    always_comb begin
        pending = PW'(post_valid) + PW'(fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            pending = pending + PW'(dl_valid[i]);
        end
    end

    assign issue_ok = credit_en && (pending < PW'(FIFO_DEPTH));

    // Credit is withheld during reset; overflow is sticky, and a dropped write can only follow an uncredited launch
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_en    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            credit_en <= 1'b1;
            if ((in_valid && !issue_ok) || fifo_drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_result_collector.sv
// tb/tb_cordic_result_collector.sv - self-checking bench for cordic_result_collector
module tb_cordic_result_collector;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_tag;
    logic        issue_ok;
    logic [15:0] pipe_degree;
    logic [15:0] pipe_x;
    logic [15:0] pipe_y;
    logic [1:0]  pipe_sector;
    logic        pipe_arctan_en;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_x;
    logic [16:0] res_y;
    logic [16:0] res_degree;
    logic        res_mode;
    logic [3:0]  res_tag;
    logic        overflow_err;

    always #5 clk = ~clk;

    cordic_result_collector dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_tag         (in_tag),
        .issue_ok       (issue_ok),
        .pipe_degree    (pipe_degree),
        .pipe_x         (pipe_x),
        .pipe_y         (pipe_y),
        .pipe_sector    (pipe_sector),
        .pipe_arctan_en (pipe_arctan_en),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_x          (res_x),
        .res_y          (res_y),
        .res_degree     (res_degree),
        .res_mode       (res_mode),
        .res_tag        (res_tag),
        .overflow_err   (overflow_err)
    );

    typedef struct {
        logic        v;
        logic [3:0]  tag;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] deg;
        logic [1:0]  s;
        logic        m;
    } launch_t;

    typedef struct {
        int x;
        int y;
        int deg;
        int mode;
        int tag;
        int ready_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] deg;
        logic [1:0]  s;
        logic        m;
        int          ex;
        int          ey;
        int          edeg;
    } vec_t;

    launch_t hist [LAT];
    exp_t    model_q [$];
    int      cyc;
    bit      model_credit;
    int      n_checks;
    int      n_pass;
    vec_t    vt [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic launch_t mk(input logic v, input logic [3:0] tag, input logic [15:0] x,
                                   input logic [15:0] y, input logic [15:0] deg,
                                   input logic [1:0] s, input logic m);
        launch_t l;
        l.v = v; l.tag = tag; l.x = x; l.y = y; l.deg = deg; l.s = s; l.m = m;
        return l;
    endfunction

    function automatic launch_t mk_rand(input logic v, input logic [3:0] tag);
        return mk(v, tag, 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
    endfunction

    function automatic launch_t idle();
        return mk_rand(1'b0, 4'($urandom));
    endfunction

    // Reference: rotate back by s quarter turns (rotation mode), angle modulo 360 degrees
    function automatic exp_t ref_result(input launch_t l);
        exp_t e;
        int   t;
        e.x = int'(l.x);
        e.y = int'(l.y);
        if (!l.m) begin
            for (int k = 0; k < int'(l.s); k++) begin
                t   = e.x;
                e.x = -e.y;
                e.y = t;
            end
        end
        e.deg       = (int'(l.deg) + int'(l.s) * 23040) % 92160;
        e.mode      = int'(l.m);
        e.tag       = int'(l.tag);
        e.ready_cyc = 0;
        return e;
    endfunction

    // One clock: drive inputs, act as the pipeline (output = launch LAT cycles ago), update the model
    task automatic step(input launch_t l, input bit rdy, input bit track);
        bit   pop_now;
        exp_t e;
        in_valid  = l.v;
        in_tag    = l.tag;
        res_ready = rdy;
        if (hist[LAT-1].v) begin
            pipe_x         = hist[LAT-1].x;
            pipe_y         = hist[LAT-1].y;
            pipe_degree    = hist[LAT-1].deg;
            pipe_sector    = hist[LAT-1].s;
            pipe_arctan_en = hist[LAT-1].m;
        end else begin
            pipe_x         = 16'($urandom);
            pipe_y         = 16'($urandom);
            pipe_degree    = 16'($urandom);
            pipe_sector    = 2'($urandom);
            pipe_arctan_en = 1'($urandom);
        end
        pop_now     = rdy && (model_q.size() > 0) && (model_q[0].ready_cyc <= cyc);
        e           = ref_result(l);
        e.ready_cyc = cyc + LAT + 2;
        @(posedge clk);
        cyc++;
        for (int k = LAT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = l;
        if (reset) begin
            model_q.delete();
            model_credit = 1'b0;
        end else begin
            model_credit = 1'b1;
            if (pop_now) void'(model_q.pop_front());
            if (l.v && track) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (model_q.size() > 0) && (model_q[0].ready_cyc <= cyc);
        check("issue_ok", issue_ok, longint'(model_credit && (model_q.size() < 4)));
        check("res_valid", res_valid, longint'(ev));
        if (ev && res_valid) begin
            check("rnd_x", longint'($signed(res_x)), model_q[0].x);
            check("rnd_y", longint'($signed(res_y)), model_q[0].y);
            check("rnd_deg", res_degree, model_q[0].deg);
            check("rnd_mode", res_mode, model_q[0].mode);
            check("rnd_tag", res_tag, model_q[0].tag);
        end
    endtask

    initial begin
        int acc;
        int seen;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        model_credit = 1'b0;
        for (int k = 0; k < LAT; k++) hist[k] = idle();
        reset = 1'b1; in_valid = 1'b0; in_tag = '0; res_ready = 1'b0;
        pipe_x = '0; pipe_y = '0; pipe_degree = '0; pipe_sector = '0; pipe_arctan_en = 1'b0;

        vt[0] = '{16'h0100, 16'h01BB, 16'h0100, 2'd0, 1'b0, 256, 443, 256};
        vt[1] = '{16'h0100, 16'h01BB, 16'h0100, 2'd1, 1'b0, -443, 256, 23296};
        vt[2] = '{16'h0100, 16'h01BB, 16'h0100, 2'd2, 1'b0, -256, -443, 46336};
        vt[3] = '{16'h0100, 16'h01BB, 16'h0100, 2'd3, 1'b0, 443, -256, 69376};
        vt[4] = '{16'h1000, 16'h0040, 16'h2D00, 2'd3, 1'b1, 4096, 64, 80640};
        vt[5] = '{16'h8000, 16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 65535, -32768, 42495};
        vt[6] = '{16'h7FFF, 16'h0000, 16'hC000, 2'd2, 1'b0, -32767, 0, 3072};
        vt[7] = '{16'hFFFF, 16'hFFFF, 16'h0000, 2'd2, 1'b1, 65535, 65535, 46080};

        @(negedge clk);
        step(idle(), 1'b0, 1'b1);
        step(idle(), 1'b0, 1'b1);
        check("rst_res_valid", res_valid, 0);
        check("rst_issue_ok", issue_ok, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_res_x", res_x, 0);
        check("rst_res_degree", res_degree, 0);
        reset = 1'b0;
        step(idle(), 1'b0, 1'b1);
        check("issue_ok_after_reset", issue_ok, 1);

        // Table vectors: single launch, latency, unfolded values, then pop
        for (int i = 0; i < 8; i++) begin
            int c0;
            int waited;
            c0 = cyc;
            step(mk(1'b1, 4'(i), vt[i].x, vt[i].y, vt[i].deg, vt[i].s, vt[i].m), 1'b0, 1'b1);
            waited = 0;
            while (!res_valid && waited < 20) begin
                step(idle(), 1'b0, 1'b1);
                waited++;
            end
            check($sformatf("vec%0d_latency", i), cyc - c0, 9);
            check($sformatf("vec%0d_x", i), longint'($signed(res_x)), vt[i].ex);
            check($sformatf("vec%0d_y", i), longint'($signed(res_y)), vt[i].ey);
            check($sformatf("vec%0d_deg", i), res_degree, vt[i].edeg);
            check($sformatf("vec%0d_mode", i), res_mode, vt[i].m);
            check($sformatf("vec%0d_tag", i), res_tag, i);
            step(idle(), 1'b1, 1'b1);
            check($sformatf("vec%0d_popped", i), res_valid, 0);
        end

        // Credit exhaustion with a stalled consumer, then an uncredited fifth launch
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (issue_ok) begin
                step(mk_rand(1'b1, 4'(10 + acc)), 1'b0, 1'b1);
                acc++;
            end else begin
                step(idle(), 1'b0, 1'b1);
            end
        end
        check("credit_accepted", acc, 4);
        check("credit_exhausted", issue_ok, 0);
        step(mk_rand(1'b1, 4'hE), 1'b0, 1'b0);
        check("overflow_set", overflow_err, 1);
        repeat (12) step(idle(), 1'b0, 1'b1);
        check("overflow_sticky", overflow_err, 1);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d_valid", j), res_valid, 1);
            check($sformatf("drain%0d_tag", j), res_tag, 10 + j);
            step(idle(), 1'b1, 1'b1);
            if (j == 0) check("credit_after_pop", issue_ok, 1);
        end
        check("fifth_dropped", res_valid, 0);

        // Reset with three samples in flight; the pipeline keeps draining them
        for (int i = 0; i < 3; i++) step(mk_rand(1'b1, 4'(i)), 1'b0, 1'b1);
        repeat (2) step(idle(), 1'b0, 1'b1);
        reset = 1'b1;
        step(idle(), 1'b0, 1'b1);
        check("midrst_issue_ok_low", issue_ok, 0);
        reset = 1'b0;
        step(idle(), 1'b0, 1'b1);
        check("midrst_issue_ok", issue_ok, 1);
        check("midrst_overflow", overflow_err, 0);
        seen = 0;
        repeat (15) begin
            if (res_valid) seen++;
            step(idle(), 1'b1, 1'b1);
        end
        check("midrst_no_result", seen, 0);

        // Randomized traffic against the reference model
        repeat (600) begin
            launch_t l;
            bit go;
            check_outputs();
            go = model_credit && (model_q.size() < 4) && ($urandom_range(0, 3) != 0);
            l  = go ? mk_rand(1'b1, 4'($urandom)) : idle();
            step(l, $urandom_range(0, 9) < 6, 1'b1);
        end
        repeat (20) begin
            check_outputs();
            step(idle(), 1'b1, 1'b1);
        end
        check("final_empty", res_valid, 0);
        check("final_model_empty", model_q.size(), 0);
        check("final_overflow", overflow_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
